// File: rtl/cbus_ram_responder_pkg.sv
// Shared CBus types and constants for the RAM responder slice.
// Beat-address arithmetic lives here so the top and any future slaves agree on it.
package cbus_ram_responder_pkg;

  localparam int unsigned CBUS_BEAT_BYTES = 8;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef logic [2:0] msize_t;
  typedef logic [3:0] mlen_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  // FIXED repeats the start address; anything else advances one 8-byte word per beat.
  function automatic logic [63:0] beat_addr(input logic [63:0] addr,
                                            input logic [1:0]  burst,
                                            input mlen_t       beat);
    logic [63:0] result;
    if (burst == AXI_BURST_FIXED) begin
      result = addr;
    end else begin
      result = addr + {57'd0, beat, 3'd0};
    end
    return result;
  endfunction

endpackage

// File: rtl/cbus_ram_responder_if.sv
// CBus request/response bundle between a requester (master) and the RAM responder (slave).
interface cbus_ram_responder_if;
  import cbus_ram_responder_pkg::*;

  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       err;

  modport master (output creq, input cresp, input err);
  modport slave  (input creq, output cresp, output err);

endinterface

// File: rtl/cbus_ram_responder_array.sv
// 64-bit word array: one synchronous read port with a clearable output register and one
// byte-strobed write port. Contents are never reset so tests can preload them directly.
module cbus_ram_responder_array #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  input  logic                  rd_clr,
  output logic [63:0]           rd_data,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [7:0]            wr_strobe,
  input  logic [63:0]           wr_data
);

  logic [63:0] mem_r [0:(1<<DEPTH_LOG2)-1];
  logic [63:0] rd_data_r;

  // byte-strobed write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (wr_strobe[i]) begin
          mem_r[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  // sync read; clear zeroes the output register (idle, writes, out-of-range beats)
  always_ff @(posedge clk) begin
    if (rd_clr) begin
      rd_data_r <= 64'd0;
    end else begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/cbus_ram_responder.sv
// CBus memory endpoint: single/burst reads and writes against an on-chip word array with
// a fixed access latency. All response outputs come straight from registers.
module cbus_ram_responder
  import cbus_ram_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input logic                  clk,
  input logic                  reset,
  cbus_ram_responder_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_BURST = 2'd2} state_t;

  localparam int          CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [63:0] ARRAY_BYTES = 64'd8 << DEPTH_LOG2;

  state_t            state_r, state_nxt_s;
  mlen_t             beat_r, beat_nxt_s, len_r, len_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [63:0]       addr_r, addr_nxt_s;
  logic [1:0]        burst_r, burst_nxt_s;
  logic              wr_r, wr_nxt_s, start_s;
  logic              err_seen_r, err_seen_nxt_s, ready_r, ready_nxt_s;
  logic              last_r, last_nxt_s, err_r, err_nxt_s;
  logic [63:0]       cur_addr_s, cur_off_s, nxt_addr_s, nxt_off_s, rd_data_s;
  logic              cur_ok_s, nxt_ok_s, rd_clr_s, wr_en_s;
  logic              unused_s;

  // next-state: the request is only looked at in IDLE
  always_comb begin
    state_nxt_s = state_r;
    beat_nxt_s  = beat_r;
    cnt_nxt_s   = cnt_r;
    addr_nxt_s  = addr_r;
    len_nxt_s   = len_r;
    burst_nxt_s = burst_r;
    wr_nxt_s    = wr_r;
    start_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.creq.valid) begin
          start_s     = 1'b1;
          state_nxt_s = ST_WAIT;
          beat_nxt_s  = 4'd0;
          cnt_nxt_s   = CNT_W'(LATENCY - 1);
          addr_nxt_s  = bus.creq.addr;
          len_nxt_s   = bus.creq.len;
          burst_nxt_s = bus.creq.burst;
          wr_nxt_s    = bus.creq.is_write;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ST_BURST;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_BURST: begin
        if (beat_r == len_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          beat_nxt_s = beat_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // cur_* is the beat completing at this edge, nxt_* is the beat presented after it
  always_comb begin
    cur_addr_s     = beat_addr(addr_r, burst_r, beat_r);
    cur_off_s      = cur_addr_s - BASE_ADDR;
    cur_ok_s       = (cur_addr_s >= BASE_ADDR) && (cur_off_s < ARRAY_BYTES);
    nxt_addr_s     = beat_addr(addr_nxt_s, burst_nxt_s, beat_nxt_s);
    nxt_off_s      = nxt_addr_s - BASE_ADDR;
    nxt_ok_s       = (nxt_addr_s >= BASE_ADDR) && (nxt_off_s < ARRAY_BYTES);
    ready_nxt_s    = (state_nxt_s == ST_BURST);
    last_nxt_s     = ready_nxt_s && (beat_nxt_s == len_nxt_s);
    err_nxt_s      = ready_nxt_s && !nxt_ok_s && !err_seen_r;
    err_seen_nxt_s = start_s ? 1'b0 : (err_seen_r | err_nxt_s);
    rd_clr_s       = reset || !ready_nxt_s || wr_nxt_s || !nxt_ok_s;
    wr_en_s        = !reset && (state_r == ST_BURST) && wr_r && cur_ok_s;
  end

  // state and registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      beat_r     <= 4'd0;
      cnt_r      <= {CNT_W{1'b0}};
      addr_r     <= 64'd0;
      len_r      <= 4'd0;
      burst_r    <= 2'd0;
      wr_r       <= 1'b0;
      err_seen_r <= 1'b0;
      ready_r    <= 1'b0;
      last_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      beat_r     <= beat_nxt_s;
      cnt_r      <= cnt_nxt_s;
      addr_r     <= addr_nxt_s;
      len_r      <= len_nxt_s;
      burst_r    <= burst_nxt_s;
      wr_r       <= wr_nxt_s;
      err_seen_r <= err_seen_nxt_s;
      ready_r    <= ready_nxt_s;
      last_r     <= last_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  cbus_ram_responder_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk       (clk),
    .rd_addr   (nxt_off_s[DEPTH_LOG2+2:3]),
    .rd_clr    (rd_clr_s),
    .rd_data   (rd_data_s),
    .wr_en     (wr_en_s),
    .wr_addr   (cur_off_s[DEPTH_LOG2+2:3]),
    .wr_strobe (bus.creq.strobe),
    .wr_data   (bus.creq.data)
  );

  assign bus.cresp = '{ready: ready_r, last: last_r, data: rd_data_s};
  assign bus.err   = err_r;
  assign unused_s  = ^{bus.creq.size};

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Directed bench for cbus_ram_responder: single-beat vector table plus burst, boundary,
// reset-abort and back-to-back sequences.
module tb_cbus_ram_responder;
  import cbus_ram_responder_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  cbus_ram_responder_if bus ();

  cbus_ram_responder #(.DEPTH_LOG2(12), .BASE_ADDR(64'h8000_0000), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic [63:0] exp;
    int          exp_err;
  } vec_t;

  vec_t        vecs [11];
  logic [63:0] beat_data [16];
  int          nbeats, first_edge, nerr, last_idx, last_cnt, extra;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // one complete transaction; valid rises at a negedge, drops after the last beat's edge
  task automatic run_req(input logic w, input logic [63:0] a, input logic [7:0] s,
                         input logic [63:0] d, input logic [3:0] l, input logic [1:0] b);
    nbeats = 0; first_edge = -1; nerr = 0; last_idx = -1; last_cnt = 0; extra = 0;
    @(negedge clk);
    bus.creq.valid = 1'b1; bus.creq.is_write = w; bus.creq.size = 3'd3;
    bus.creq.addr = a; bus.creq.strobe = s; bus.creq.data = d;
    bus.creq.len = l; bus.creq.burst = b;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (bus.err) nerr++;
      if (bus.cresp.ready) begin
        if (nbeats == 0) first_edge = e;
        if (nbeats < 16) beat_data[nbeats] = bus.cresp.data;
        if (bus.cresp.last) begin
          last_cnt++;
          last_idx = nbeats;
        end
        nbeats++;
        if (bus.cresp.last) break;
      end
    end
    @(posedge clk); #1;
    if (bus.cresp.ready || bus.err) extra++;
    bus.creq.valid = 1'b0;
    @(posedge clk); #1;
    if (bus.cresp.ready || bus.err) extra++;
  endtask

  task automatic chk_shape(input string nm, input int beats, input int errs);
    chk({nm, " beats"}, 64'(nbeats), 64'(beats));
    chk({nm, " last_idx"}, 64'(last_idx), 64'(beats - 1));
    chk({nm, " last_cnt"}, 64'(last_cnt), 64'd1);
    chk({nm, " first_edge"}, 64'(first_edge), 64'(LAT + 1));
    chk({nm, " err_cnt"}, 64'(nerr), 64'(errs));
    chk({nm, " extra"}, 64'(extra), 64'd0);
  endtask

  initial begin
    bus.creq = '0;
    for (int i = 0; i < 4096; i++) dut.u_array.mem_r[i] = 64'd0;
    dut.u_array.mem_r[0] = 64'h1122_3344_5566_7788;
    for (int i = 0; i < 4; i++) dut.u_array.mem_r[32 + i] = 64'(i);
    dut.u_array.mem_r[4094] = 64'hAAAA_0000_AAAA_0000;
    dut.u_array.mem_r[4095] = 64'hBBBB_1111_BBBB_1111;

    vecs[0]  = '{1'b0, 64'h8000_0000, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 0};
    vecs[1]  = '{1'b1, 64'h8000_0008, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0};
    vecs[2]  = '{1'b0, 64'h8000_0008, 8'h00, 64'd0, 64'h0000_0000_FFFF_FFFF, 0};
    vecs[3]  = '{1'b0, 64'h8000_0003, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 0};
    vecs[4]  = '{1'b1, 64'h8000_0010, 8'hF0, 64'h0123_4567_89AB_CDEF, 64'd0, 0};
    vecs[5]  = '{1'b0, 64'h8000_0010, 8'h00, 64'd0, 64'h0123_4567_0000_0000, 0};
    vecs[6]  = '{1'b0, 64'h7FFF_FFF8, 8'h00, 64'd0, 64'd0, 1};
    vecs[7]  = '{1'b1, 64'h8000_8000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[8]  = '{1'b0, 64'h8000_7FF8, 8'h00, 64'd0, 64'hBBBB_1111_BBBB_1111, 0};
    vecs[9]  = '{1'b0, 64'h8000_8000, 8'h00, 64'd0, 64'd0, 1};
    vecs[10] = '{1'b0, 64'h8000_0000, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset cresp", 64'({bus.cresp.ready, bus.cresp.last}) | bus.cresp.data, 64'd0);
    chk("reset err", 64'(bus.err), 64'd0);
    reset = 1'b0;

    for (int v = 0; v < 11; v++) begin
      run_req(vecs[v].w, vecs[v].addr, vecs[v].strb, vecs[v].wdata, 4'd0, AXI_BURST_INCR);
      chk_shape($sformatf("vec%0d", v), 1, vecs[v].exp_err);
      chk($sformatf("vec%0d data", v), beat_data[0], vecs[v].exp);
    end

    run_req(1'b0, 64'h8000_0100, 8'h00, 64'd0, 4'd3, AXI_BURST_INCR);
    chk_shape("incr4", 4, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("incr4 d%0d", i), beat_data[i], 64'(i));

    run_req(1'b0, 64'h8000_0100, 8'h00, 64'd0, 4'd3, AXI_BURST_FIXED);
    chk_shape("fixed0", 4, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("fixed0 d%0d", i), beat_data[i], 64'd0);

    run_req(1'b0, 64'h8000_0108, 8'h00, 64'd0, 4'd3, AXI_BURST_FIXED);
    chk_shape("fixed1", 4, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("fixed1 d%0d", i), beat_data[i], 64'd1);

    // INCR running off the top of the array: two real words, then two zero beats
    run_req(1'b0, 64'h8000_7FF0, 8'h00, 64'd0, 4'd3, AXI_BURST_INCR);
    chk_shape("top", 4, 1);
    chk("top d0", beat_data[0], 64'hAAAA_0000_AAAA_0000);
    chk("top d1", beat_data[1], 64'hBBBB_1111_BBBB_1111);
    chk("top d2", beat_data[2], 64'd0);
    chk("top d3", beat_data[3], 64'd0);

    // reset during beat 2 of an 8-beat INCR write
    @(negedge clk);
    bus.creq.valid = 1'b1; bus.creq.is_write = 1'b1; bus.creq.addr = 64'h8000_0200;
    bus.creq.strobe = 8'hFF; bus.creq.data = 64'h5A5A_5A5A_5A5A_5A5A;
    bus.creq.len = 4'd7; bus.creq.burst = AXI_BURST_INCR;
    nbeats = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (bus.cresp.ready) nbeats++;
      if (nbeats == 3) break;
    end
    chk("abort reached beat2", 64'(nbeats), 64'd3);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort cresp", 64'({bus.cresp.ready, bus.cresp.last}) | bus.cresp.data, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.creq.valid = 1'b0;
    @(posedge clk);

    run_req(1'b0, 64'h8000_0200, 8'h00, 64'd0, 4'd7, AXI_BURST_INCR);
    chk_shape("after abort", 8, 0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("abort word%0d", i), beat_data[i],
          (i < 2) ? 64'h5A5A_5A5A_5A5A_5A5A : 64'd0);

    // two requests separated by one low-valid cycle
    run_req(1'b0, 64'h8000_0108, 8'h00, 64'd0, 4'd1, AXI_BURST_INCR);
    chk_shape("b2b first", 2, 0);
    chk("b2b first d0", beat_data[0], 64'd1);
    chk("b2b first d1", beat_data[1], 64'd2);
    run_req(1'b0, 64'h8000_0118, 8'h00, 64'd0, 4'd0, AXI_BURST_INCR);
    chk_shape("b2b second", 1, 0);
    chk("b2b second d0", beat_data[0], 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
